// File: rtl/uart_tx_serializer_if.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer_if
//
// Purpose: byte handshake between the channel-rotation stage (master) and the
//          UART transmitter (slave).
//
// Signals:
//   send   master -> slave  transmit request, sampled every clock
//   data   master -> slave  byte to transmit, sampled only on accept
//   ready  slave -> master  high when the transmitter can accept a byte
//   done   slave -> master  one-clock pulse when the last stop bit completes
// -----------------------------------------------------------------------------
interface uart_tx_serializer_if;
    logic       send;
    logic [7:0] data;
    logic       ready;
    logic       done;

    modport master (
        output send,
        output data,
        input  ready,
        input  done
    );

    modport slave (
        input  send,
        input  data,
        output ready,
        output done
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
//
// Purpose: byte-wide UART transmitter for the ADC telemetry path. Frames each
//          accepted byte as start bit, 8 data bits LSB first, optional parity
//          bit and 1 or 2 stop bits. Every bit lasts BAUD_DIV system clocks.
//
// Parameters:
//   BAUD_DIV   system clocks per bit period (2..65535)
//   PARITY     0 = none, 1 = even, 2 = odd
//   STOP_BITS  1 or 2
//
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous, active-low reset
//   bus        slave side of the send/data/ready/done handshake
//   txPin      serial line, idle high
//
// All outputs (txPin, ready, done) are registered.
// -----------------------------------------------------------------------------
module uart_tx_serializer #(
    parameter int BAUD_DIV  = 5208,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    uart_tx_serializer_if.slave   bus,
    output logic                  txPin
);

    localparam int               CNT_W     = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(BAUD_DIV - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic             ODD_PAR   = (PARITY == 2);

    generate
        if (BAUD_DIV < 2 || BAUD_DIV > 65535 || PARITY < 0 || PARITY > 2 ||
            (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_params
            $error("uart_tx_serializer: illegal BAUD_DIV/PARITY/STOP_BITS");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [CNT_W-1:0] r_baud_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_parity;
    logic             r_stop_cnt;

    logic             r_tx;
    logic             r_ready;
    logic             r_done;

    logic             w_accept;
    logic             w_bit_end;
    logic             w_last_data;
    logic             w_last_stop;
    logic [7:0]       w_shift_next;
    logic             w_tx_next;
    logic             w_ready_next;
    logic             w_done_next;

    // r_ready is high exactly when the FSM is idle, so it doubles as the
    // accept qualifier without another decode of the state.
    assign w_accept    = bus.send & r_ready;
    assign w_bit_end   = (r_baud_cnt == CNT_MAX);
    assign w_last_data = (r_bit_idx == 3'd7);
    assign w_last_stop = (r_stop_cnt == STOP_LAST);

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_next = S_START;
            end
            S_START: begin
                if (w_bit_end) w_state_next = S_DATA;
            end
            S_DATA: begin
                if (w_bit_end && w_last_data) begin
                    if (PARITY != 0) w_state_next = S_PARITY;
                    else             w_state_next = S_STOP;
                end
            end
            S_PARITY: begin
                if (w_bit_end) w_state_next = S_STOP;
            end
            S_STOP: begin
                if (w_bit_end && w_last_stop) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Bit timing, bit/stop counters, shift register and latched parity
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'd0;
            r_parity   <= 1'b0;
            r_stop_cnt <= 1'b0;
        end else begin
            // Held at 0 while idle so the start bit gets a full period.
            if (r_state == S_IDLE || w_bit_end) r_baud_cnt <= '0;
            else                                r_baud_cnt <= r_baud_cnt + CNT_W'(1);

            // Wraps 7 -> 0 so the next frame starts from bit 0.
            if (r_state == S_DATA && w_bit_end) r_bit_idx <= r_bit_idx + 3'd1;

            if (r_state == S_STOP && w_bit_end) r_stop_cnt <= w_last_stop ? 1'b0 : ~r_stop_cnt;

            r_shift <= w_shift_next;

            if (w_accept) r_parity <= (^bus.data) ^ ODD_PAR;
        end
    end

    // Output logic: outputs are computed from the upcoming state so that the
    // registered pins change on the same edge as the state.
    always_comb begin
        w_shift_next = r_shift;
        if (w_accept)                            w_shift_next = bus.data;
        else if (r_state == S_DATA && w_bit_end) w_shift_next = {1'b0, r_shift[7:1]};

        w_tx_next = 1'b1;
        case (w_state_next)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = w_shift_next[0];
            S_PARITY: w_tx_next = r_parity;
            default:  w_tx_next = 1'b1;
        endcase

        w_ready_next = (w_state_next == S_IDLE);
        w_done_next  = (r_state == S_STOP) && (w_state_next == S_IDLE);
    end

    // Output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_tx    <= 1'b1;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_tx    <= w_tx_next;
            r_ready <= w_ready_next;
            r_done  <= w_done_next;
        end
    end

    assign txPin     = r_tx;
    assign bus.ready = r_ready;
    assign bus.done  = r_done;

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Byte-wide UART transmitter for the ADC telemetry path.
- Sits directly downstream of the channel-rotation stage and consumes one byte per send/ready handshake.
- Frames each byte as start, 8 data bits LSB first, optional parity, and 1 or 2 stop bits, then drives txPin.
- Bit timing comes from an internal divider of the system clock.

Parameters:
- BAUD_DIV, 5208: system clocks per bit period (50 MHz / 9600). Legal range 2..65535.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  reset, asynchronous, active-low.
- send  input  1  transmit request, sampled each clock.
- data  input  8  byte to transmit, sampled only on accept.
- txPin  output  1  serial line, idle high.
- ready  output  1  high when idle and able to accept a byte.
- done  output  1  one-clock pulse when the final stop bit completes.

Behaviour:
- Reset values (async on reset=0):
  - txPin=1, ready=1, done=0.
  - State=IDLE; baud counter, bit index and shift register cleared.
- Reset asserted mid-frame aborts the frame immediately: txPin returns high with no partial stop bit. The frame is never resumed.
- Accept: send=1 and ready=1 on the same rising edge. At that edge:
  - data is latched into the shift register.
  - Parity is computed from the latched byte.
  - ready goes 0.
  - State becomes START.
- data changes after accept have no effect on the frame in flight.
- send=1 while ready=0 is ignored. It is not queued.
- Latency: txPin goes low on the first clock after the accept edge. All outputs are registered.
- Bit timing:
  - The baud counter runs 0..BAUD_DIV-1.
  - Every bit, including start, parity and stop, is held exactly BAUD_DIV clocks.
  - The counter reloads to 0 at each bit boundary.
- FSM states:
  - IDLE: txPin=1, ready=1. Goes to START on accept.
  - START: txPin=0 for one bit period, then DATA with bit index 0.
  - DATA: txPin=shift[0]; shift right at each bit boundary. After bit index 7, go to PARITY if PARITY != 0, otherwise go to STOP.
  - PARITY: txPin carries the parity bit for one bit period, then STOP.
    - Even parity: XOR of the data bits.
    - Odd parity: inverted XOR of the data bits.
  - STOP: txPin=1 for STOP_BITS bit periods. At the end of the last one: done=1 for one clock, ready=1, state goes to IDLE.
- Frame length is (1 + 8 + P + STOP_BITS) × BAUD_DIV clocks, where P = 1 if PARITY != 0, else 0. ready is low for exactly this many clocks.
- Back-to-back operation with send held high:
  - A byte is re-accepted on the first edge at which ready=1.
  - There is therefore exactly one idle-high clock between frames.
  - Frame period is frame length + 1 clocks.
- done and ready rise on the same clock. An accept on that clock is legal.
- Illegal parameter values (BAUD_DIV<2, PARITY>2, STOP_BITS not 1 or 2) are a synthesis-time error. There is no runtime handling.

Test Plan:
1. BAUD_DIV=4, PARITY=0, STOP_BITS=1. Pulse send with data=0x55.
   -> txPin = 0,1,0,1,0,1,0,1,0,1, each held 4 clocks.
   -> ready low for exactly 40 clocks; done pulses once on the final clock.
2. PARITY=1 (even), data=0x07.
   -> Parity bit is 1; frame is 11 bits = 44 clocks.
   -> Repeat with PARITY=2 (odd) and data=0x00: parity bit is 1.
3. STOP_BITS=2, data=0xFF.
   -> txPin is low for exactly 4 clocks (start bit), then high for 40 clocks.
   -> ready returns on clock 44.
4. send held high. data=0xA5 for the first frame, switched to 0x3C mid-frame.
   -> First frame carries 0xA5; second frame carries 0x3C.
   -> Exactly 1 idle-high clock between the end of the stop bit and the next start bit.
5. Assert send again during the data bits of a frame.
   -> Frame is unchanged; no second frame follows after ready returns if send is low by then.
6. Assert reset during data bit 3 of a 0x00 frame.
   -> txPin=1, ready=1, done=0 immediately, with no clock edge needed.
   -> After release, a new send of 0x81 transmits a clean full frame.
